// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor, Diff = A - B - Bin, one bit
//               per clock LSB first, using a single full-subtractor cell and
//               a borrow flip-flop. start/busy/done handshake per operation.
//               Optional signed-overflow output enabled by the macro
//               SERIAL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    // Holds the WIDTH-1 result bits already produced; the final bit joins
    // them combinationally on the last shift cycle.
    logic [WIDTH-2:0]   r_sr;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic               w_d;
    logic               w_br_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_res;

    // Full-subtractor cell on the current LSBs.
    assign w_d       = r_a_sr[0] ^ r_b_sr[0] ^ r_br;
    assign w_br_next = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_br);
    assign w_last    = (r_state == SHIFT) && (r_cnt == c_LAST);
    assign w_res     = {w_d, r_sr};

    assign busy = r_busy;
    assign done = r_done;
    assign Diff = r_diff;
    assign Bout = r_bout;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after WIDTH bits.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_sr   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else begin
            r_busy <= (w_next == SHIFT);
            r_done <= (w_next == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr <= A;
                        r_b_sr <= B;
                        r_br   <= Bin;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_br   <= w_br_next;
                    r_sr   <= w_res[WIDTH-1:1];
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    if (w_last) begin
                        r_diff <= w_res;
                        r_bout <= w_br_next;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    assign Ovf = r_ovf;

    // Operand MSBs are captured at start because the shift registers lose them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_a_msb <= A[WIDTH-1];
                r_b_msb <= B[WIDTH-1];
            end
            if (w_last) begin
                r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor with borrow-in, the sequential counterpart to the lab's combinational full adder. It computes `Diff = A - B - Bin` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. A start/busy/done handshake frames each operation. It sits beside the adder blocks as the area-minimal arithmetic unit for the DSD lab datapath exercises.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new operation. Sampled only in IDLE.
- `A`, input, WIDTH: minuend. Captured on the accepted `start` edge.
- `B`, input, WIDTH: subtrahend. Captured on the accepted `start` edge.
- `Bin`, input, 1: borrow-in. Captured on the accepted `start` edge.
- `busy`, output, 1: high while bits are being processed.
- `done`, output, 1: one-cycle pulse when the result is valid.
- `Diff`, output, WIDTH: result; holds its value until the next completion.
- `Bout`, output, 1: borrow-out of the MSB; holds with `Diff`.
- `Ovf`, output, 1: signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- **States:** IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE:**
  - If `start`=1, load shift registers `a_sr<=A` and `b_sr<=B`, load `br<=Bin`, clear `cnt<=0`, and go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT, each cycle:**
  - `d = a_sr[0]^b_sr[0]^br`.
  - `br <= (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&br)`.
  - Shift `d` into the MSB of the internal `r_sr`.
  - Shift `a_sr` and `b_sr` right by one bit.
  - `cnt<=cnt+1`.
  - When `cnt==WIDTH-1` this cycle, go to DONE.
- **Entry to DONE:**
  - `Diff <= {d, r_sr[WIDTH-1:1]}`, the fully assembled result.
  - `Bout <= final borrow`.
  - `Ovf` is updated at the same edge (see Configuration).
- **DONE:** lasts exactly one cycle, then returns unconditionally to IDLE.
- **`start` outside IDLE:** ignored in SHIFT and DONE. It is not queued.
- **Arithmetic:** the result is modulo 2^WIDTH, and `Bout`=1 iff `A < B+Bin` as unsigned values.
- **Counter:** `cnt` is `$clog2(WIDTH)` bits wide and never wraps within an operation.
- **Reset (`rst`=1 at any edge, including mid-SHIFT):**
  - Go to IDLE.
  - `busy`, `done`, `Diff`, `Bout` and `Ovf` all become 0.
  - Internal shift registers and `cnt` clear.
  - The partial operation is discarded.
- **Reset and `start` in the same cycle:** reset wins and `start` is dropped.

## Timing
- **Reset values:** `busy`=0, `done`=0, `Diff`=0, `Bout`=0, `Ovf`=0.
- **Accept to busy:** `start` is accepted at edge k, and `busy`=1 from after edge k through edge k+WIDTH, i.e. exactly WIDTH cycles.
- **Result latency:**
  - `done`=1 for the single cycle after edge k+WIDTH.
  - `Diff`, `Bout` and `Ovf` are valid in that same cycle.
  - Latency from `start` to `done` is therefore WIDTH+1 edges.
- **Overlap:** `busy` and `done` are never high together.
- **Back-to-back:** earliest next accepted `start` is at edge k+WIDTH+2, since IDLE is re-entered at edge k+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- **Output stability:** `Diff`, `Bout` and `Ovf` change only on DONE entry or reset. They never show partial values.
- **Registered outputs:** all outputs are registers, with no combinational path from inputs to outputs.

## Configuration
- **`SERIAL_SUB_OVF_EN` defined:**
  - Port `Ovf` exists.
  - At DONE entry, `Ovf <= (A_msb ^ B_msb) & (A_msb ^ Diff_msb)`, using the captured operand MSBs.
  - This treats operands as two's complement, with `Bin` included in the subtraction.
- **`SERIAL_SUB_OVF_EN` undefined:**
  - No `Ovf` port and no related logic.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- **Simple subtract:** `A`=0x05, `B`=0x03, `Bin`=0, pulse `start` -> `busy` for 8 cycles, then `done` pulse with `Diff`=0x02, `Bout`=0, `Ovf`=0.
- **Underflow:** `A`=0x03, `B`=0x05, `Bin`=0 -> `Diff`=0xFE, `Bout`=1, `Ovf`=0.
- **Borrow-in:** `A`=0x00, `B`=0x00, `Bin`=1 -> `Diff`=0xFF, `Bout`=1.
- **Signed overflow:** `A`=0x80, `B`=0x01, `Bin`=0 -> `Diff`=0x7F, `Bout`=0, `Ovf`=1 with the macro defined; the `Ovf` port is absent without it.
- **Handshake:**
  - Hold `start`=1 continuously with changing `A`/`B` -> each operation uses the operands captured at its accepted edge.
  - `done` occurs every 10 cycles.
  - `busy` and `done` are never high together.
- **Reset mid-operation:**
  - Start `A`=0x55, `B`=0x11, then assert `rst` in the 3rd SHIFT cycle -> next cycle shows IDLE with all outputs 0 and no `done`.
  - A fresh start with `A`=0x55, `B`=0x11 -> `Diff`=0x44, `Bout`=0.
